ysyx_writeback_unit: RTL and testbench

//   Write-back stage directly upstream of the 32x32 register file. Accepts one retiring

---
 rtl/ysyx_wb_pkg.sv | 21 ++
 rtl/ysyx_load_extend.sv | 35 +++
 rtl/ysyx_writeback_unit.sv | 135 +++++++++++++
 tb/tb_ysyx_writeback_unit.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/ysyx_wb_pkg.sv
// Shared encodings for the write-back stage: result-select codes, load funct3 codes, FSM states.
package ysyx_wb_pkg;

   localparam logic [1:0] WB_ALU  = 2'b00;
   localparam logic [1:0] WB_LOAD = 2'b01;
   localparam logic [1:0] WB_PC4  = 2'b10;
   localparam logic [1:0] WB_CSR  = 2'b11;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_MEM = 2'd1,
      WRITE    = 2'd2
   } wb_state_t;

endpackage

// File: rtl/ysyx_load_extend.sv
// Combinational load-data aligner/extender: picks the byte/half/word at the low address bits
// out of an aligned word and sign- or zero-extends it; unknown funct3 yields 0 with err set.
module ysyx_load_extend
   import ysyx_wb_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  off,
   input  logic [2:0]  funct3,
   output logic [31:0] data,
   output logic        err
);

   logic [31:0] shifted;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   assign shifted = rdata >> {off, 3'b000};
   assign ld_byte = shifted[7:0];
   // Halfword selection uses only addr[1]; addr[0] is deliberately ignored.
   assign ld_half = off[1] ? rdata[31:16] : rdata[15:0];

   always_comb begin
      data = '0;
      err  = 1'b0;
      case (funct3)
         F3_LB:   data = {{24{ld_byte[7]}}, ld_byte};
         F3_LBU:  data = {24'd0, ld_byte};
         F3_LH:   data = {{16{ld_half[15]}}, ld_half};
         F3_LHU:  data = {16'd0, ld_half};
         F3_LW:   data = rdata;
         default: err  = 1'b1;
      endcase
   end

endmodule

// File: rtl/ysyx_writeback_unit.sv
// Write-back stage: accepts one retiring instruction, waits for load data if needed,
// then drives the register-file write port and a one-cycle commit strobe.
module ysyx_writeback_unit
   import ysyx_wb_pkg::*;
#(
   parameter int          XLEN     = 32,
   parameter int          RF_AW    = 5,
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [XLEN-1:0]  in_pc,
   input  logic [XLEN-1:0]  in_next_pc,
   input  logic [RF_AW-1:0] in_rd,
   input  logic             in_rd_wen,
   input  logic [1:0]       in_wb_sel,
   input  logic [XLEN-1:0]  in_alu_res,
   input  logic [XLEN-1:0]  in_csr_rdata,
   input  logic [2:0]       in_funct3,
   input  logic             mem_rvalid,
   input  logic [XLEN-1:0]  mem_rdata,
   output logic             mem_rready,
   output logic             rf_wr_en,
   output logic [RF_AW-1:0] rf_waddr,
   output logic [XLEN-1:0]  rf_wdata,
   output logic             commit_valid,
   output logic [XLEN-1:0]  commit_pc,
   output logic [XLEN-1:0]  commit_next_pc,
   output logic             commit_err
);

   wb_state_t state_q, state_d;

   logic [XLEN-1:0]  pc_q, npc_q;
   logic [RF_AW-1:0] rd_q;
   logic             wen_q;
   logic [1:0]       off_q;
   logic [2:0]       f3_q;

   logic [XLEN-1:0]  imm_res, ld_data;
   logic             ld_err;
   logic             accept, load_done;

   assign accept    = (state_q == IDLE) && in_valid;
   assign load_done = (state_q == WAIT_MEM) && mem_rvalid;

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      in_ready   = 1'b0;
      mem_rready = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = (in_wb_sel == WB_LOAD) ? WAIT_MEM : WRITE;
         end
         WAIT_MEM: begin
            mem_rready = 1'b1;
            if (mem_rvalid) state_d = WRITE;
         end
         WRITE:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      case (in_wb_sel)
         WB_PC4:  imm_res = in_pc + 32'd4;
         WB_CSR:  imm_res = in_csr_rdata;
         default: imm_res = in_alu_res;
      endcase
   end

   ysyx_load_extend u_ext (
      .rdata  (mem_rdata),
      .off    (off_q),
      .funct3 (f3_q),
      .data   (ld_data),
      .err    (ld_err)
   );

   // Outputs are registered on the edge that enters WRITE, so they hold across IDLE/WAIT_MEM.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q           <= '0;
         npc_q          <= '0;
         rd_q           <= '0;
         wen_q          <= 1'b0;
         off_q          <= '0;
         f3_q           <= '0;
         rf_wr_en       <= 1'b0;
         rf_waddr       <= '0;
         rf_wdata       <= '0;
         commit_valid   <= 1'b0;
         commit_pc      <= '0;
         commit_next_pc <= RESET_PC;
         commit_err     <= 1'b0;
      end else begin
         rf_wr_en     <= 1'b0;
         commit_valid <= 1'b0;
         commit_err   <= 1'b0;
         if (accept) begin
            pc_q  <= in_pc;
            npc_q <= in_next_pc;
            rd_q  <= in_rd;
            wen_q <= in_rd_wen;
            off_q <= in_alu_res[1:0];
            f3_q  <= in_funct3;
         end
         if (accept && (in_wb_sel != WB_LOAD)) begin
            rf_wr_en       <= in_rd_wen && (in_rd != '0);
            rf_waddr       <= in_rd;
            rf_wdata       <= imm_res;
            commit_valid   <= 1'b1;
            commit_pc      <= in_pc;
            commit_next_pc <= in_next_pc;
         end else if (load_done) begin
            rf_wr_en       <= wen_q && (rd_q != '0);
            rf_waddr       <= rd_q;
            rf_wdata       <= ld_data;
            commit_valid   <= 1'b1;
            commit_pc      <= pc_q;
            commit_next_pc <= npc_q;
            commit_err     <= ld_err;
         end
      end
   end

endmodule

// File: tb/tb_ysyx_writeback_unit.sv
// Directed bench for the write-back stage: ALU/JAL/CSR/load paths, x0 suppression, reset mid-load.
module tb_ysyx_writeback_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready;
   logic [31:0] in_pc, in_next_pc, in_alu_res, in_csr_rdata;
   logic [4:0]  in_rd;
   logic        in_rd_wen;
   logic [1:0]  in_wb_sel;
   logic [2:0]  in_funct3;
   logic        mem_rvalid, mem_rready;
   logic [31:0] mem_rdata;
   logic        rf_wr_en;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        commit_valid, commit_err;
   logic [31:0] commit_pc, commit_next_pc;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   ysyx_writeback_unit dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_next_pc(in_next_pc), .in_rd(in_rd), .in_rd_wen(in_rd_wen),
      .in_wb_sel(in_wb_sel), .in_alu_res(in_alu_res), .in_csr_rdata(in_csr_rdata),
      .in_funct3(in_funct3),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rready(mem_rready),
      .rf_wr_en(rf_wr_en), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_next_pc(commit_next_pc),
      .commit_err(commit_err)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Presents one instruction for one accept edge; DUT must be in IDLE.
   task automatic issue(input logic [31:0] pc, input logic [31:0] npc, input logic [4:0] rd,
                        input logic wen, input logic [1:0] sel, input logic [31:0] alu,
                        input logic [31:0] csr, input logic [2:0] f3);
      in_valid = 1'b1; in_pc = pc; in_next_pc = npc; in_rd = rd; in_rd_wen = wen;
      in_wb_sel = sel; in_alu_res = alu; in_csr_rdata = csr; in_funct3 = f3;
      step();
      in_valid = 1'b0; in_alu_res = 32'h0; in_pc = 32'h0; in_rd = 5'd0;
   endtask

   task automatic load_resp(input logic [31:0] data);
      mem_rvalid = 1'b1; mem_rdata = data;
      step();
      mem_rvalid = 1'b0; mem_rdata = 32'h0;
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_pc = '0; in_next_pc = '0; in_rd = '0; in_rd_wen = 1'b0;
      in_wb_sel = 2'b00; in_alu_res = '0; in_csr_rdata = '0; in_funct3 = '0;
      mem_rvalid = 1'b0; mem_rdata = '0;
      step(); step();
      rst_n = 1'b1;

      // Reset state
      chk("rst_in_ready", in_ready, 1);
      chk("rst_mem_rready", mem_rready, 0);
      chk("rst_rf_wr_en", rf_wr_en, 0);
      chk("rst_waddr", rf_waddr, 0);
      chk("rst_wdata", rf_wdata, 0);
      chk("rst_commit_valid", commit_valid, 0);
      chk("rst_commit_pc", commit_pc, 0);
      chk("rst_commit_npc", commit_next_pc, 32'h8000_0000);
      chk("rst_commit_err", commit_err, 0);

      // 1. ALU op
      issue(32'h8000_0000, 32'h8000_0004, 5'd5, 1'b1, 2'b00, 32'h1234_5678, 32'h0, 3'b000);
      chk("alu_wr_en", rf_wr_en, 1);
      chk("alu_waddr", rf_waddr, 5);
      chk("alu_wdata", rf_wdata, 32'h1234_5678);
      chk("alu_commit", commit_valid, 1);
      chk("alu_commit_pc", commit_pc, 32'h8000_0000);
      chk("alu_in_ready_low", in_ready, 0);
      step();
      chk("alu_in_ready_back", in_ready, 1);
      chk("alu_wr_en_drop", rf_wr_en, 0);
      chk("alu_commit_drop", commit_valid, 0);
      chk("alu_waddr_hold", rf_waddr, 5);
      chk("alu_wdata_hold", rf_wdata, 32'h1234_5678);

      // 2. JAL
      issue(32'h8000_0010, 32'h8000_0100, 5'd1, 1'b1, 2'b10, 32'h0, 32'h0, 3'b000);
      chk("jal_wdata", rf_wdata, 32'h8000_0014);
      chk("jal_npc", commit_next_pc, 32'h8000_0100);
      chk("jal_waddr", rf_waddr, 1);
      step();
      chk("jal_npc_hold", commit_next_pc, 32'h8000_0100);

      // CSR read result, plus PC+4 wrap-around
      issue(32'h0000_0040, 32'h0000_0044, 5'd9, 1'b1, 2'b11, 32'h0, 32'hCAFE_F00D, 3'b000);
      chk("csr_wdata", rf_wdata, 32'hCAFE_F00D);
      step();
      issue(32'hFFFF_FFFC, 32'h0, 5'd2, 1'b1, 2'b10, 32'h0, 32'h0, 3'b000);
      chk("pc4_wrap", rf_wdata, 32'h0000_0000);
      step();

      // 3. LB with addr[1:0]=3, 4-cycle wait
      issue(32'h8000_0020, 32'h8000_0024, 5'd6, 1'b1, 2'b01, 32'h0000_1003, 32'h0, 3'b000);
      for (int i = 0; i < 4; i++) begin
         chk("lb_wait_rready", mem_rready, 1);
         chk("lb_wait_no_wr", rf_wr_en, 0);
         chk("lb_wait_no_commit", commit_valid, 0);
         chk("lb_wait_in_ready", in_ready, 0);
         step();
      end
      load_resp(32'h80FF_0000);
      chk("lb_wr_en", rf_wr_en, 1);
      chk("lb_wdata", rf_wdata, 32'hFFFF_FF80);
      chk("lb_commit_pc", commit_pc, 32'h8000_0020);
      chk("lb_err", commit_err, 0);
      chk("lb_rready_off", mem_rready, 0);
      step();

      // LBU
      issue(32'h8000_0024, 32'h8000_0028, 5'd7, 1'b1, 2'b01, 32'h0000_1003, 32'h0, 3'b100);
      step(); step(); step();
      chk("lbu_wait_no_wr", rf_wr_en, 0);
      load_resp(32'h80FF_0000);
      chk("lbu_wdata", rf_wdata, 32'h0000_0080);
      chk("lbu_waddr", rf_waddr, 7);
      step();

      // 4. LH upper half, then unsupported funct3
      issue(32'h8000_0030, 32'h8000_0034, 5'd8, 1'b1, 2'b01, 32'h0000_2002, 32'h0, 3'b001);
      load_resp(32'h8001_7FFF);
      chk("lh_wdata", rf_wdata, 32'hFFFF_8001);
      step();
      issue(32'h8000_0034, 32'h8000_0038, 5'd8, 1'b1, 2'b01, 32'h0000_2000, 32'h0, 3'b011);
      load_resp(32'h8001_7FFF);
      chk("bad_f3_wdata", rf_wdata, 32'h0);
      chk("bad_f3_err", commit_err, 1);
      chk("bad_f3_commit", commit_valid, 1);
      step();
      chk("bad_f3_err_drop", commit_err, 0);

      // LHU lower half and LW
      issue(32'h8000_0038, 32'h8000_003C, 5'd10, 1'b1, 2'b01, 32'h0000_2001, 32'h0, 3'b101);
      load_resp(32'h8001_8FFE);
      chk("lhu_wdata", rf_wdata, 32'h0000_8FFE);
      step();
      issue(32'h8000_003C, 32'h8000_0040, 5'd11, 1'b1, 2'b01, 32'h0000_2003, 32'h0, 3'b010);
      load_resp(32'hA5A5_0F0F);
      chk("lw_wdata", rf_wdata, 32'hA5A5_0F0F);
      step();

      // 5. x0 and rd_wen=0
      issue(32'h8000_0050, 32'h8000_0054, 5'd0, 1'b1, 2'b00, 32'hDEAD_BEEF, 32'h0, 3'b000);
      chk("x0_wr_en", rf_wr_en, 0);
      chk("x0_commit", commit_valid, 1);
      step();
      issue(32'h8000_0054, 32'h8000_0058, 5'd7, 1'b0, 2'b00, 32'h1111_2222, 32'h0, 3'b000);
      chk("nowen_wr_en", rf_wr_en, 0);
      chk("nowen_commit", commit_valid, 1);
      step();

      // 6. Reset mid-load
      issue(32'h8000_0060, 32'h8000_0064, 5'd12, 1'b1, 2'b01, 32'h0, 32'h0, 3'b010);
      step();
      chk("mid_rready", mem_rready, 1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      load_resp(32'h1234_5678);
      chk("rst_load_wr_en", rf_wr_en, 0);
      chk("rst_load_commit", commit_valid, 0);
      chk("rst_load_in_ready", in_ready, 1);
      chk("rst_load_npc", commit_next_pc, 32'h8000_0000);
      chk("rst_load_rready", mem_rready, 0);
      step();
      chk("rst_load_wr_en2", rf_wr_en, 0);
      chk("rst_load_commit2", commit_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
